// File: rtl/cfg_reg_bank_arbiter_pkg.sv
// Shared constants and helpers for the configuration register bank arbiter.
package cfg_reg_bank_arbiter_pkg;

    localparam int MAX_REQ = 8;
    localparam int BCW     = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cfg_reg_bank_arbiter_if.sv
// Requester write channel plus register-bank and notification outputs.
interface cfg_reg_bank_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 6,
    parameter int AW       = 3
);
    import cfg_reg_bank_arbiter_pkg::*;

    localparam int OW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*AW-1:0]     req_addr;
    logic [NUM_REQ*WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REGS*WIDTH-1:0] reg_q;
    logic                      wr_valid;
    logic [OW-1:0]             wr_owner;
    logic [AW-1:0]             wr_addr;
    logic                      err_addr;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, reg_q, wr_valid, wr_owner, wr_addr, err_addr
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, reg_q, wr_valid, wr_owner, wr_addr, err_addr
    );

endinterface

// File: rtl/cfg_reg_bank_arbiter_rr_priority_pick.sv
// Rotating priority picker: first valid requester at or after ptr, wrapping.
// Purely combinational, no backpressure of its own.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [IW:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!any_o && valid_i[cand[IW-1:0]]) begin
                any_o = 1'b1;
                idx_o = cand[IW-1:0];
            end
        end
        gnt_o[idx_o] = any_o;
    end

endmodule

// File: rtl/cfg_reg_bank_arbiter.sv
// Round-robin shared config register bank with bounded burst lock.
// Grant is combinational; writes land and notify one cycle after acceptance.
module cfg_reg_bank_arbiter
    import cfg_reg_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int NUM_REGS  = 6,
    parameter int AW        = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cfg_reg_bank_arbiter_if.slave bus
);
    localparam int IW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      win_idx;
    logic               any_vld;
    logic               accept;
    logic               in_range;
    logic               win_lock;
    logic [AW-1:0]      win_addr;
    logic [WIDTH-1:0]   win_data;

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [BCW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0]   bank_q [NUM_REGS];
    logic               wr_valid_q;
    logic               err_addr_q;
    logic [IW-1:0]      wr_owner_q;
    logic [AW-1:0]      wr_addr_q;

    rr_priority_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (win_idx),
        .any_o   (any_vld)
    );

    assign bus.req_ready = rst ? '0 : gnt;
    assign accept        = any_vld & ~rst;
    assign win_addr      = bus.req_addr[int'(win_idx)*AW +: AW];
    assign win_data      = bus.req_data[int'(win_idx)*WIDTH +: WIDTH];
    assign win_lock      = bus.req_lock[win_idx];
    assign in_range      = ({1'b0, win_addr} < (AW+1)'(NUM_REGS));

    // Locked owner keeps priority until MAX_BURST writes; any idle cycle ends the burst.
    always_comb begin
        ptr_d       = ptr_q;
        burst_cnt_d = '0;
        if (accept) begin
            if (win_lock && (({1'b0, burst_cnt_q} + (BCW+1)'(1)) < (BCW+1)'(MAX_BURST))) begin
                ptr_d       = win_idx;
                burst_cnt_d = burst_cnt_q + BCW'(1);
            end else begin
                ptr_d = (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            burst_cnt_q <= '0;
            wr_valid_q  <= 1'b0;
            err_addr_q  <= 1'b0;
            wr_owner_q  <= '0;
            wr_addr_q   <= '0;
            for (int r = 0; r < NUM_REGS; r++) bank_q[r] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_valid_q  <= accept & in_range;
            err_addr_q  <= accept & ~in_range;
            if (accept) begin
                wr_owner_q <= win_idx;
                wr_addr_q  <= win_addr;
            end
            if (accept && in_range) bank_q[win_addr] <= win_data;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_regq
        assign bus.reg_q[r*WIDTH +: WIDTH] = bank_q[r];
    end

    assign bus.wr_valid = wr_valid_q;
    assign bus.err_addr = err_addr_q;
    assign bus.wr_owner = wr_owner_q;
    assign bus.wr_addr  = wr_addr_q;

endmodule

// File: doc/cfg_reg_bank_arbiter.md
Name: cfg_reg_bank_arbiter

Overview:
- Shares one bank of configuration registers between NUM_REQ requesters.
- Each requester issues single-word writes using a valid/ready handshake.
- Round-robin arbitration grants at most one write per cycle. A bounded lock lets a requester do short back-to-back bursts.
- Sits between the control-plane masters and the datapath configuration registers; it drives the stored register values and a registered write-notification strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, register data width.
- NUM_REGS, 6, number of registers in the bank (1..2**AW).
- AW, 3, address width.
- MAX_BURST, 4, maximum consecutive accepted locked writes by one owner before priority must rotate (1..15).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_lock  in  NUM_REQ  per-requester burst-lock hint, sampled with valid.
- req_addr  in  NUM_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_data  in  NUM_REQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot-or-zero grant, combinational from valid and state.
- reg_q  out  NUM_REGS*WIDTH  packed register contents; register r uses bits [r*WIDTH +: WIDTH].
- wr_valid  out  1  registered pulse, one cycle after each accepted in-range write.
- wr_owner  out  clog2(NUM_REQ)  requester index of the write reported by wr_valid.
- wr_addr  out  AW  address of the write reported by wr_valid.
- err_addr  out  1  registered pulse, one cycle after an accepted write with addr >= NUM_REGS.

Behaviour:
- Reset (async, rst=1) sets all of the following immediately:
  - reg_q = 0.
  - wr_valid = 0, err_addr = 0.
  - wr_owner = 0, wr_addr = 0.
  - Priority pointer ptr = 0, burst_cnt = 0.
  - req_ready = 0 while rst is high.
- Arbitration (combinational):
  - The winner is the first requester with req_valid=1, searching from ptr upward with wrap-around.
  - req_ready[winner] = 1; all other ready bits = 0.
  - If no requester is valid, req_ready = 0.
- Handshake: a write is accepted in a cycle where req_valid[i] & req_ready[i]. There is at most one acceptance per cycle.
- Register update:
  - On the accepting edge, bank[addr] <= data when addr < NUM_REGS; it is visible on reg_q in the next cycle.
  - Out-of-range writes are accepted and dropped, and err_addr pulses. They still count for pointer and burst rules.
- Notification: wr_valid, wr_owner and wr_addr are registered, valid the cycle after acceptance. wr_valid and err_addr are never both 1.
- Pointer/lock state machine, per acceptance by winner w:
  - If req_lock[w]=1 and burst_cnt+1 < MAX_BURST: ptr <= w, burst_cnt <= burst_cnt+1.
  - Otherwise: ptr <= (w+1) mod NUM_REQ, burst_cnt <= 0.
  - If there is no acceptance in a cycle: ptr holds and burst_cnt <= 0. An idle cycle breaks the burst.
  - If the owner deasserts req_valid mid-burst, the next winner is searched from ptr (= w); others win only once w is idle.
- MAX_BURST=1: lock has no effect; pure round-robin.
- Requesters must hold addr and data stable while valid is high and ready is low. The block does not check this.
- Reset asserted mid-burst: all state clears at once; the first grant after release goes to the lowest-index valid requester.

Decomposition:
- Shared package/header: MAX_REQ=8, constant function clog2 (ceiling log2), burst-counter width BCW=4.
- One sub-module, rr_priority_pick: NUM_REQ-wide rotating priority picker.
  - Inputs: valid vector, ptr.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational.
- Register bank, burst counter and notification registers stay in the top.

Test Plan:
- Reset, then req_valid[2]=1, addr=1, data=0xDEADBEEF → req_ready=0100 in the same cycle; next cycle reg_q[1]=0xDEADBEEF, wr_valid=1, wr_owner=2, wr_addr=1; other registers remain 0.
- All four requesters valid, lock=0, held 8 cycles → grants in order 0,1,2,3,0,1,2,3; exactly one ready bit per cycle.
- Requester 1 valid with lock=1, requester 3 valid, MAX_BURST=4 → grants 1,1,1,1,3,1,… (rotation forced after 4).
- Requester 0 writes addr=6 with NUM_REGS=6 → next cycle err_addr=1, wr_valid=0, reg_q unchanged; ptr advances to 1.
- Assert rst for one cycle during a locked burst by requester 2 while requesters 0 and 2 are valid → outputs zero asynchronously; first grant after release goes to 0.
- Requester 1 locked burst of 2 writes, one idle cycle, then requesters 0 and 1 both valid → burst_cnt restarted; ptr=1, so requester 1 wins first.
